// File: rtl/commit_retire_pkg.sv
// =============================================================================
// Module      : commit_retire_pkg
// Description : Shared instruction-buffer types plus the retirement FSM states.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package commit_retire_pkg;

    localparam int BUF_SIZE     = 8;
    localparam int BUF_SIZE_LOG = 3;

    typedef logic [4:0]              tag_t;
    typedef logic [BUF_SIZE_LOG-1:0] index_t;
    typedef logic [5:0]              spectag_t;
    typedef logic [1:0]              rwmm_t;

    typedef enum logic [1:0] {
        S_NOT_USED  = 2'd0,
        S_WAITING   = 2'd1,
        S_EXECUTING = 2'd2,
        S_EXECUTED  = 2'd3
    } e_state_t;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        LOAD   = 2'd1,
        STORE  = 2'd2,
        BRANCH = 2'd3
    } unit_t;

    typedef struct packed {
        e_state_t    e_state;
        unit_t       unit;
        tag_t        tag;
        spectag_t    speculative_tag;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] vk;
        rwmm_t       rwmm;
    } entry_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_STORE = 1'b1
    } commit_state_t;

endpackage

`default_nettype wire

// File: rtl/commit_retire_oldest_pair_finder.sv
// =============================================================================
// Module      : oldest_pair_finder
// Description : Linear scan returning the two used entries with the largest tags.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module oldest_pair_finder
    import commit_retire_pkg::*;
(
    input  entry_t       i_entries [BUF_SIZE],
    output logic [1:0]   o_valid,
    output index_t [1:0] o_index,
    output tag_t [1:0]   o_tag
);

    logic [1:0]   w_valid;
    index_t [1:0] w_index;
    tag_t [1:0]   w_tag;

    // A new maximum pushes the previous oldest down to the second slot.
    always_comb begin
        w_valid = 2'b00;
        w_index = '0;
        w_tag   = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (i_entries[i].e_state != S_NOT_USED) begin
                if (!w_valid[0] || (i_entries[i].tag > w_tag[0])) begin
                    w_valid[1] = w_valid[0];
                    w_index[1] = w_index[0];
                    w_tag[1]   = w_tag[0];
                    w_valid[0] = 1'b1;
                    w_index[0] = index_t'(i);
                    w_tag[0]   = i_entries[i].tag;
                end else if (!w_valid[1] || (i_entries[i].tag > w_tag[1])) begin
                    w_valid[1] = 1'b1;
                    w_index[1] = index_t'(i);
                    w_tag[1]   = i_entries[i].tag;
                end
            end
        end
    end

    assign o_valid = w_valid;
    assign o_index = w_index;
    assign o_tag   = w_tag;

endmodule

`default_nettype wire

// File: rtl/commit_retire.sv
// =============================================================================
// Module      : commit_retire
// Description : In-order retirement of up to two instructions per cycle, stores
//               via req/ack handshake, 64-bit retired-instruction counter.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module commit_retire
    import commit_retire_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  entry_t            entries_all [BUF_SIZE],
    output logic [1:0]        free_valid,
    output index_t [1:0]      free_index,
    output logic [1:0]        reg_we,
    output logic [1:0][4:0]   reg_waddr,
    output logic [1:0][31:0]  reg_wdata,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output rwmm_t             mem_size,
    input  logic              mem_ack,
    output logic [63:0]       instret,
    output logic              stalled
);

    logic [1:0]    w_valid;
    index_t [1:0]  w_index;
    tag_t [1:0]    w_tag;
    entry_t        w_slot [2];
    logic [1:0]    w_retirable;
    logic          w_latch_store;
    commit_state_t w_next_state;

    commit_state_t r_state;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    rwmm_t         r_mem_size;
    index_t        r_store_idx;
    logic [63:0]   r_instret;

    oldest_pair_finder u_finder (
        .i_entries (entries_all),
        .o_valid   (w_valid),
        .o_index   (w_index),
        .o_tag     (w_tag)
    );

    assign w_slot[0] = entries_all[w_index[0]];
    assign w_slot[1] = entries_all[w_index[1]];

    for (genvar k = 0; k < 2; k++) begin : g_retirable
        assign w_retirable[k] = w_valid[k] && (w_slot[k].e_state == S_EXECUTED)
                                && (w_slot[k].speculative_tag == '0);
    end

    always_comb begin
        free_valid    = 2'b00;
        free_index    = w_index;
        reg_we        = 2'b00;
        reg_waddr[0]  = w_slot[0].dest;
        reg_waddr[1]  = w_slot[1].dest;
        reg_wdata[0]  = w_slot[0].result;
        reg_wdata[1]  = w_slot[1].result;
        w_latch_store = 1'b0;
        w_next_state  = r_state;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_retirable[0] && (w_slot[0].unit == STORE)) begin
                        w_latch_store = 1'b1;
                        w_next_state  = S_STORE;
                    end else if (w_retirable[0]) begin
                        free_valid[0] = 1'b1;
                        reg_we[0]     = (w_slot[0].dest != 5'd0);
                        if (w_retirable[1] && (w_slot[1].unit != STORE)) begin
                            free_valid[1] = 1'b1;
                            reg_we[1]     = (w_slot[1].dest != 5'd0);
                            // Younger write wins on a shared destination.
                            if (reg_we[1] && (w_slot[0].dest == w_slot[1].dest))
                                reg_we[0] = 1'b0;
                        end
                    end
                end
                S_STORE: begin
                    free_index[0] = r_store_idx;
                    if (mem_ack) begin
                        free_valid[0] = 1'b1;
                        w_next_state  = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
            r_store_idx <= '0;
            r_instret   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_mem_req <= (w_next_state == S_STORE);
            r_instret <= r_instret + 64'(free_valid[0]) + 64'(free_valid[1]);
            if (w_latch_store) begin
                r_mem_addr  <= w_slot[0].result;
                r_mem_wdata <= w_slot[0].vk;
                r_mem_size  <= w_slot[0].rwmm;
                r_store_idx <= w_index[0];
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;
    assign instret   = r_instret;
    assign stalled   = (r_state == S_STORE);

endmodule

`default_nettype wire

// File: tb/tb_commit_retire.sv
// =============================================================================
// Module      : tb_commit_retire
// Description : Directed plus randomized snapshots checked against a reference model.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_commit_retire;
    import commit_retire_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    entry_t           ent [BUF_SIZE];
    entry_t           nxt [BUF_SIZE];
    logic [1:0]       free_valid;
    index_t [1:0]     free_index;
    logic [1:0]       reg_we;
    logic [1:0][4:0]  reg_waddr;
    logic [1:0][31:0] reg_wdata;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    rwmm_t            mem_size;
    logic             mem_ack;
    logic [63:0]      instret;
    logic             stalled;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_store;
    int          m_idx;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [63:0] m_instret;

    always #5 clk = ~clk;

    commit_retire dut (
        .clk        (clk),
        .reset      (reset),
        .entries_all(ent),
        .free_valid (free_valid),
        .free_index (free_index),
        .reg_we     (reg_we),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_size   (mem_size),
        .mem_ack    (mem_ack),
        .instret    (instret),
        .stalled    (stalled)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic entry_t mk(input int tag, input e_state_t st, input unit_t u,
                                  input int spec, input int dest, input logic [31:0] res,
                                  input logic [31:0] vk);
        entry_t e;
        e.e_state         = st;
        e.unit            = u;
        e.tag             = tag_t'(tag);
        e.speculative_tag = spectag_t'(spec);
        e.dest            = 5'(dest);
        e.result          = res;
        e.vk              = vk;
        e.rwmm            = 2'(dest);
        return e;
    endfunction

    task automatic clear_nxt();
        for (int i = 0; i < BUF_SIZE; i++) nxt[i] = '0;
    endtask

    // One cycle: apply staged inputs, compare against the model, advance the model.
    task automatic step(input logic ack, input logic rst);
        int o0, o1;
        logic r0, r1;
        logic [1:0] efv, ewe;
        int efi [2];
        logic [4:0] ewa [2];
        logic [31:0] ewd [2];
        @(negedge clk);
        for (int i = 0; i < BUF_SIZE; i++) ent[i] = nxt[i];
        mem_ack = ack;
        reset   = rst;
        #1;
        o0 = -1; o1 = -1;
        for (int i = 0; i < BUF_SIZE; i++)
            if (ent[i].e_state != S_NOT_USED && (o0 < 0 || ent[i].tag > ent[o0].tag)) o0 = i;
        for (int i = 0; i < BUF_SIZE; i++)
            if (i != o0 && ent[i].e_state != S_NOT_USED && (o1 < 0 || ent[i].tag > ent[o1].tag)) o1 = i;
        r0 = (o0 >= 0) && ent[o0].e_state == S_EXECUTED && ent[o0].speculative_tag == 0;
        r1 = (o1 >= 0) && ent[o1].e_state == S_EXECUTED && ent[o1].speculative_tag == 0;
        efv = 2'b00; ewe = 2'b00;
        efi[0] = o0; efi[1] = o1;
        ewa[0] = 0; ewa[1] = 0; ewd[0] = 0; ewd[1] = 0;
        if (o0 >= 0) begin ewa[0] = ent[o0].dest; ewd[0] = ent[o0].result; end
        if (o1 >= 0) begin ewa[1] = ent[o1].dest; ewd[1] = ent[o1].result; end
        if (!rst) begin
            if (m_store) begin
                if (ack) begin efv[0] = 1'b1; efi[0] = m_idx; end
            end else if (r0 && ent[o0].unit != STORE) begin
                efv[0] = 1'b1;
                ewe[0] = ewa[0] != 0;
                if (r1 && ent[o1].unit != STORE) begin
                    efv[1] = 1'b1;
                    ewe[1] = ewa[1] != 0;
                    if (ewe[1] && ewa[0] == ewa[1]) ewe[0] = 1'b0;
                end
            end
        end
        check("free_valid", 64'(free_valid), 64'(efv));
        for (int k = 0; k < 2; k++) begin
            if (efv[k]) check("free_index", 64'(free_index[k]), 64'(efi[k]));
            if (ewe[k]) begin
                check("reg_waddr", 64'(reg_waddr[k]), 64'(ewa[k]));
                check("reg_wdata", 64'(reg_wdata[k]), 64'(ewd[k]));
            end
        end
        check("reg_we", 64'(reg_we), 64'(ewe));
        check("mem_req", 64'(mem_req), 64'(m_store));
        check("mem_addr", 64'(mem_addr), 64'(m_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        check("mem_size", 64'(mem_size), 64'(m_size));
        check("instret", instret, m_instret);
        check("stalled", 64'(stalled), 64'(m_store));
        if (rst) begin
            m_store = 0; m_addr = 0; m_wdata = 0; m_size = 0; m_instret = 0;
        end else if (m_store) begin
            if (ack) begin m_store = 0; m_instret = m_instret + 1; end
        end else if (r0 && ent[o0].unit == STORE) begin
            m_store = 1; m_idx = o0;
            m_addr = ent[o0].result; m_wdata = ent[o0].vk; m_size = ent[o0].rwmm;
        end else begin
            m_instret = m_instret + 64'(efv[0]) + 64'(efv[1]);
        end
    endtask

    task automatic randomize_nxt();
        logic [31:0] taken;
        int t;
        taken = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            do t = $urandom_range(0, 31); while (taken[t]);
            taken[t] = 1'b1;
            nxt[i] = mk(t,
                        ($urandom_range(0, 3) == 0) ? S_NOT_USED :
                        ($urandom_range(0, 2) != 0) ? S_EXECUTED : S_WAITING,
                        ($urandom_range(0, 5) == 0) ? STORE : unit_t'($urandom_range(0, 3)),
                        ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 63)) : 0,
                        $urandom_range(0, 6), $urandom, $urandom);
        end
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0;
        clear_nxt();
        for (int i = 0; i < BUF_SIZE; i++) ent[i] = '0;
        m_store = 0; m_idx = 0; m_addr = 0; m_wdata = 0; m_size = 0; m_instret = 0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Two executed ALU entries retire together
        nxt[2] = mk(15, S_EXECUTED, ALU, 0, 3, 32'hA, 0);
        nxt[5] = mk(14, S_EXECUTED, ALU, 0, 4, 32'hB, 0);
        step(1'b0, 1'b0);
        // Oldest not executed blocks everything
        nxt[2].e_state = S_WAITING;
        step(1'b0, 1'b0);
        // Shared destination
        nxt[2] = mk(15, S_EXECUTED, ALU, 0, 5, 32'h11, 0);
        nxt[5] = mk(14, S_EXECUTED, ALU, 0, 5, 32'h22, 0);
        step(1'b0, 1'b0);
        // Store with delayed ack
        clear_nxt();
        nxt[1] = mk(15, S_EXECUTED, STORE, 0, 2, 32'h100, 32'hDEAD);
        nxt[4] = mk(14, S_EXECUTED, ALU, 0, 6, 32'h33, 0);
        step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        nxt[1] = '0;
        step(1'b0, 1'b0);
        // Speculative oldest waits until cleared
        clear_nxt();
        nxt[0] = mk(15, S_EXECUTED, ALU, 2, 7, 32'h44, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        nxt[0].speculative_tag = '0;
        step(1'b0, 1'b0);
        // Reset abandons an outstanding store
        clear_nxt();
        nxt[3] = mk(20, S_EXECUTED, STORE, 0, 1, 32'h200, 32'hBEEF);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            randomize_nxt();
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
